stopwatch_lap: RTL and testbench

//  Parametrised successor of the board stopwatch: sub-second/second counter with

---
 rtl/stopwatch_pkg.sv | 20 ++
 rtl/stopwatch_lap_fifo.sv | 68 ++++++
 rtl/stopwatch_lap.sv | 177 +++++++++++++++++
 tb/tb_stopwatch_lap.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types for the 100 Hz stopwatch with lap capture:
// run-state encoding, lap entry layout and default count limits.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } sw_state_t;

  localparam int DEF_SUB_MAX = 99;
  localparam int DEF_SEC_MAX = 99;
  localparam int DEF_W       = 7;

  typedef struct packed {
    logic [DEF_W-1:0] sec;
    logic [DEF_W-1:0] msec;
  } lap_entry_t;

endpackage

// File: rtl/stopwatch_lap_fifo.sv
// Synchronous first-word-fall-through FIFO holding captured laps.
// Flush wins over push/pop; a pop on a full FIFO frees room for a push.
module stopwatch_lap_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = mem_q[rd_q];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is not reset; the head is masked by the top while empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/stopwatch_lap.sv
// Stopwatch on the 100 Hz tick: start/stop, clear, wrap flag, lap FIFO.
// STOPWATCH_COUNTDOWN_EN adds mode_down/preset_sec/done countdown mode.
module stopwatch_lap
  import stopwatch_pkg::*;
#(
  parameter int SUB_MAX   = DEF_SUB_MAX,
  parameter int SEC_MAX   = DEF_SEC_MAX,
  parameter int SUB_W     = DEF_W,
  parameter int SEC_W     = DEF_W,
  parameter int LAP_DEPTH = 4
) (
  input  logic                         clk100Hz,
  input  logic                         reset,
  input  logic                         start_stop,
  input  logic                         lap,
  input  logic                         clear,
  input  logic                         lap_rd,
`ifdef STOPWATCH_COUNTDOWN_EN
  input  logic                         mode_down,
  input  logic [SEC_W-1:0]             preset_sec,
  output logic                         done,
`endif
  output logic [SEC_W-1:0]             sec,
  output logic [SUB_W-1:0]             msec,
  output logic                         running,
  output logic                         wrap,
  output logic [SEC_W-1:0]             lap_sec,
  output logic [SUB_W-1:0]             lap_msec,
  output logic                         lap_valid,
  output logic [$clog2(LAP_DEPTH):0]   lap_count,
  output logic                         lap_ovf
);

  localparam int LW = SEC_W + SUB_W;

  sw_state_t        state_q, state_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [SUB_W-1:0] msec_q, msec_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             start_prev_q, lap_prev_q;
  logic             start_rise, lap_rise;
  logic             lap_push;
  logic             f_full, f_empty;
  logic [LW-1:0]    f_head;
`ifdef STOPWATCH_COUNTDOWN_EN
  logic             down_q, down_d;
  logic             done_q, done_d;
`endif

  assign start_rise = start_stop & ~start_prev_q;
  assign lap_rise   = lap & ~lap_prev_q;
  assign lap_push   = lap_rise & ~clear &
                      ((state_q == RUN) | (state_q == HOLD));

  stopwatch_lap_fifo #(
    .WIDTH (LW),
    .DEPTH (LAP_DEPTH)
  ) u_fifo (
    .clk   (clk100Hz),
    .rst   (reset),
    .flush (clear),
    .push  (lap_push),
    .pop   (lap_rd),
    .din   ({sec_q, msec_q}),
    .dout  (f_head),
    .full  (f_full),
    .empty (f_empty),
    .count (lap_count)
  );

  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    msec_d  = msec_q;
    wrap_d  = wrap_q;
    ovf_d   = ovf_q;
`ifdef STOPWATCH_COUNTDOWN_EN
    down_d  = down_q;
    done_d  = 1'b0;
`endif
    if (clear) begin
      state_d = IDLE;
      sec_d   = '0;
      msec_d  = '0;
      wrap_d  = 1'b0;
      ovf_d   = 1'b0;
`ifdef STOPWATCH_COUNTDOWN_EN
      down_d  = mode_down;
      if (mode_down) sec_d = preset_sec;
`endif
    end else begin
      if (start_rise) begin
        unique case (state_q)
          IDLE:    state_d = RUN;
          RUN:     state_d = HOLD;
          HOLD:    state_d = RUN;
          default: state_d = IDLE;
        endcase
      end
      if (state_q == RUN) begin
`ifdef STOPWATCH_COUNTDOWN_EN
        if (down_q) begin
          // Reaching 0:0 ends the run regardless of a same-cycle button.
          if (sec_q == '0 && msec_q <= SUB_W'(1)) begin
            sec_d   = '0;
            msec_d  = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (msec_q == '0) begin
            msec_d = SUB_W'(SUB_MAX);
            sec_d  = sec_q - SEC_W'(1);
          end else begin
            msec_d = msec_q - SUB_W'(1);
          end
        end else
`endif
        if (msec_q == SUB_W'(SUB_MAX)) begin
          msec_d = '0;
          if (sec_q == SEC_W'(SEC_MAX)) begin
            sec_d  = '0;
            wrap_d = 1'b1;
          end else begin
            sec_d = sec_q + SEC_W'(1);
          end
        end else begin
          msec_d = msec_q + SUB_W'(1);
        end
      end
      if (lap_push && f_full && !lap_rd) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk100Hz or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sec_q        <= '0;
      msec_q       <= '0;
      wrap_q       <= 1'b0;
      ovf_q        <= 1'b0;
      start_prev_q <= 1'b0;
      lap_prev_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sec_q        <= sec_d;
      msec_q       <= msec_d;
      wrap_q       <= wrap_d;
      ovf_q        <= ovf_d;
      start_prev_q <= start_stop;
      lap_prev_q   <= lap;
    end
  end

`ifdef STOPWATCH_COUNTDOWN_EN
  always_ff @(posedge clk100Hz or posedge reset) begin
    if (reset) begin
      down_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      down_q <= down_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
`endif

  assign sec       = sec_q;
  assign msec      = msec_q;
  assign running   = (state_q == RUN);
  assign wrap      = wrap_q;
  assign lap_ovf   = ovf_q;
  assign lap_valid = ~f_empty;
  assign lap_sec   = f_empty ? '0 : f_head[LW-1:SUB_W];
  assign lap_msec  = f_empty ? '0 : f_head[SUB_W-1:0];

endmodule

// File: tb/tb_stopwatch_lap.sv
// Directed bench for stopwatch_lap: counting, hold, wrap, lap FIFO.
// Countdown checks run when STOPWATCH_COUNTDOWN_EN is defined.
module tb_stopwatch_lap;

  logic       clk100Hz = 1'b0;
  logic       reset = 1'b1;
  logic       start_stop = 1'b0;
  logic       lap = 1'b0;
  logic       clear = 1'b0;
  logic       lap_rd = 1'b0;
  logic [6:0] sec, msec, lap_sec, lap_msec;
  logic       running, wrap, lap_valid, lap_ovf;
  logic [2:0] lap_count;
`ifdef STOPWATCH_COUNTDOWN_EN
  logic       mode_down = 1'b0;
  logic [6:0] preset_sec = '0;
  logic       done;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk100Hz = ~clk100Hz;

  stopwatch_lap dut (
    .clk100Hz   (clk100Hz),
    .reset      (reset),
    .start_stop (start_stop),
    .lap        (lap),
    .clear      (clear),
    .lap_rd     (lap_rd),
`ifdef STOPWATCH_COUNTDOWN_EN
    .mode_down  (mode_down),
    .preset_sec (preset_sec),
    .done       (done),
`endif
    .sec        (sec),
    .msec       (msec),
    .running    (running),
    .wrap       (wrap),
    .lap_sec    (lap_sec),
    .lap_msec   (lap_msec),
    .lap_valid  (lap_valid),
    .lap_count  (lap_count),
    .lap_ovf    (lap_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk100Hz);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_start();
    start_stop = 1'b1;
    tick();
    start_stop = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1;
    tick();
    lap = 1'b0;
    tick();
  endtask

  initial begin
    #1;
    check("rst_sec", sec, 0);
    check("rst_msec", msec, 0);
    check("rst_run", running, 0);
    check("rst_valid", lap_valid, 0);
    tick();
    reset = 1'b0;
    tick();

    // start, 150 counts, stop, hold, resume
    pulse_start();
    check("t2_run", running, 1);
    check("t2_msec0", msec, 0);
    ticks(149);
    pulse_start();
    check("t2_sec", sec, 1);
    check("t2_msec", msec, 50);
    check("t2_stop", running, 0);
    ticks(5);
    check("t2_hold", msec, 50);
    pulse_start();
    check("t2_resume", running, 1);
    tick();
    check("t2_inc", msec, 51);

    // reset mid-run with one lap held
    clear = 1'b1;
    tick();
    clear = 1'b0;
    pulse_start();
    ticks(30);
    lap = 1'b1;
    tick();
    lap = 1'b0;
    ticks(6);
    check("t1_msec37", msec, 37);
    check("t1_lapc", lap_count, 1);
    check("t1_lapm", lap_msec, 30);
    #2;
    reset = 1'b1;
    #1;
    check("t1_msec", msec, 0);
    check("t1_run", running, 0);
    check("t1_valid", lap_valid, 0);
    check("t1_count", lap_count, 0);
    check("t1_lapm0", lap_msec, 0);
    tick();
    reset = 1'b0;

    // wrap at 99:99
    pulse_start();
    ticks(9998);
    check("t3_sec98", sec, 99);
    check("t3_msec98", msec, 98);
    check("t3_wrap0", wrap, 0);
    tick();
    check("t3_msec99", msec, 99);
    check("t3_wrap_early", wrap, 0);
    tick();
    check("t3_sec0", sec, 0);
    check("t3_msec0", msec, 0);
    check("t3_wrap", wrap, 1);
    tick();
    check("t3_msec1", msec, 1);
    check("t3_sticky", wrap, 1);
    check("t3_run", running, 1);

    // five laps into a four-deep FIFO
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t4_clr_wrap", wrap, 0);
    check("t4_clr_run", running, 0);
    pulse_start();
    for (int i = 0; i < 5; i++) pulse_lap();
    check("t4_count", lap_count, 4);
    check("t4_ovf", lap_ovf, 1);
    for (int i = 0; i < 4; i++) begin
      check("t4_head", lap_msec, 2 * i);
      check("t4_hsec", lap_sec, 0);
      lap_rd = 1'b1;
      tick();
    end
    lap_rd = 1'b0;
    check("t4_empty", lap_valid, 0);
    check("t4_cnt0", lap_count, 0);
    check("t4_zero", lap_msec, 0);
    lap = 1'b1;
    lap_rd = 1'b1;
    tick();
    lap = 1'b0;
    lap_rd = 1'b0;
    check("t4_pp_cnt", lap_count, 1);
    check("t4_pp_head", lap_msec, 14);

    // clear discards a same-cycle lap; full + push + pop
    clear = 1'b1;
    lap = 1'b1;
    tick();
    clear = 1'b0;
    lap = 1'b0;
    check("t5_clr_cnt", lap_count, 0);
    check("t5_clr_ovf", lap_ovf, 0);
    check("t5_clr_msec", msec, 0);
    pulse_start();
    for (int i = 0; i < 4; i++) pulse_lap();
    check("t5_full", lap_count, 4);
    lap = 1'b1;
    lap_rd = 1'b1;
    tick();
    lap = 1'b0;
    lap_rd = 1'b0;
    check("t5_cnt", lap_count, 4);
    check("t5_ovf", lap_ovf, 0);
    for (int i = 0; i < 4; i++) begin
      check("t5_head", lap_msec, 2 + 2 * i);
      lap_rd = 1'b1;
      tick();
    end
    lap_rd = 1'b0;
    check("t5_empty", lap_valid, 0);

`ifdef STOPWATCH_COUNTDOWN_EN
    mode_down = 1'b1;
    preset_sec = 7'd2;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    mode_down = 1'b0;
    check("t6_sec", sec, 2);
    check("t6_msec", msec, 0);
    pulse_start();
    ticks(199);
    check("t6_m1", msec, 1);
    check("t6_s0", sec, 0);
    check("t6_run", running, 1);
    check("t6_nodone", done, 0);
    tick();
    check("t6_zero", msec, 0);
    check("t6_idle", running, 0);
    check("t6_done", done, 1);
    tick();
    check("t6_pulse", done, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
